// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the data-memory SRAM controller.
//   state_e           : access FSM states (IDLE, LOW, HIGH, DONE)
//   SRAM_ADDR_W/DATA_W: external SRAM half-word address and data bus widths
//   DATA_W            : pipeline-side word width
//   DEFAULT_BASE_ADDR : byte address that maps onto SRAM word 0
//   half_addr()       : byte address -> SRAM half-word address
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned WORD_W      = SRAM_ADDR_W - 1;

  localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  // Offset wraps modulo 2^32 and is not range-checked; the two byte-offset
  // bits are dropped and the 17-bit word index gets the half select appended.
  function automatic logic [SRAM_ADDR_W-1:0] half_addr(
    input logic [DATA_W-1:0] address,
    input logic [DATA_W-1:0] base,
    input logic              half
  );
    return {WORD_W'((address - base) >> 2), half};
  endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller: memory-stage responder that turns one 32-bit load/store
// into two 16-bit transactions on an external asynchronous SRAM.
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   wr_en      : store request (wins when rd_en is also set)
//   rd_en      : load request
//   address    : byte address of the access
//   write_data : store data
//   read_data  : registered load result, valid from DONE onwards
//   ready      : 0 freezes the pipeline, 1 = access complete or no request
//   SRAM_*     : SRAM bus; CE_N/UB_N/LB_N permanently enabled
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 1   // hold cycles per half, 1..7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [DATA_W-1:0]      address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);

  localparam int unsigned CNT_W = 3;

  state_e                 state, nxt_state;
  logic [CNT_W-1:0]       cnt, nxt_cnt;
  logic                   wr_q, nxt_wr;
  logic                   last;
  logic                   req;

  logic                   nxt_we_n, nxt_oe_n, nxt_dq_en;
  logic [SRAM_DATA_W-1:0] nxt_dq;
  logic [SRAM_ADDR_W-1:0] nxt_addr;
  logic                   dq_en;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic [SRAM_DATA_W-1:0] low_half;

  assign req   = wr_en | rd_en;
  assign last  = (cnt == CNT_W'(WAIT_CYCLES));
  assign ready = ~req | (state == DONE);

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = dq_en ? dq_out : {SRAM_DATA_W{1'bz}};

  // Next state, plus the bus image for the cycle that next state represents,
  // so the SRAM strobes come straight out of flops.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_wr    = wr_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          nxt_state = LOW;
          nxt_cnt   = '0;
          nxt_wr    = wr_en;
        end
      end
      LOW: begin
        if (last) begin
          nxt_state = HIGH;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (last) begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      DONE: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
      default: nxt_state = IDLE;
    endcase

    nxt_we_n  = 1'b1;
    nxt_oe_n  = 1'b1;
    nxt_dq_en = 1'b0;
    nxt_dq    = dq_out;
    nxt_addr  = SRAM_ADDR;
    if (nxt_state == LOW || nxt_state == HIGH) begin
      // Address and data follow the live inputs, so a dropped request still
      // strobes whatever is presented at the time.
      nxt_addr = half_addr(address, BASE_ADDR, nxt_state == HIGH);
      if (nxt_wr) begin
        nxt_dq_en = 1'b1;
        nxt_dq    = (nxt_state == HIGH) ? write_data[31:16] : write_data[15:0];
        // Strobe released on the last cycle of the half so address and data
        // are held one cycle past the rising edge of WE_N.
        nxt_we_n  = !(32'(nxt_cnt) < WAIT_CYCLES);
      end else begin
        nxt_oe_n = 1'b0;
      end
    end
  end

  // Control and bus strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      dq_en     <= 1'b0;
      SRAM_ADDR <= '0;
      read_data <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      wr_q      <= nxt_wr;
      SRAM_WE_N <= nxt_we_n;
      SRAM_OE_N <= nxt_oe_n;
      dq_en     <= nxt_dq_en;
      SRAM_ADDR <= nxt_addr;
      if (state == HIGH && last && !wr_q)
        read_data <= {SRAM_DQ, low_half};
    end
  end

  // Data-only registers
  always_ff @(posedge clk) begin
    dq_out <= nxt_dq;
    if (state == LOW && last && !wr_q)
      low_half <= SRAM_DQ;
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-stage responder for the pipeline's data-memory requests.
- Accepts the execute stage's memory request: wr_en/rd_en, 32-bit byte address, 32-bit store data.
- Performs each 32-bit access as two 16-bit transactions on the external asynchronous SRAM.
- Holds ready low for the duration of the access so the pipeline freezes; returns load data registered.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1: extra hold cycles per 16-bit half. Legal range 1..7.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  store request; held stable while ready=0.
- rd_en  in  1  load request; held stable while ready=0.
- address  in  32  byte address of the access.
- write_data  in  32  store data.
- read_data  out  32  load result, registered.
- ready  out  1  0 = freeze pipeline; 1 = access complete or no request.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_WE_N  out  1  write strobe, active-low.
- SRAM_OE_N  out  1  output enable, active-low.
- SRAM_CE_N  out  1  chip enable; tied 0.
- SRAM_UB_N  out  1  upper byte enable; tied 0.
- SRAM_LB_N  out  1  lower byte enable; tied 0.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE, cnt=0, read_data=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ released (Z), SRAM_ADDR=0.
  - A transaction in progress is abandoned; the request is restarted from IDLE once rst returns to 1.
- Address mapping:
  - off = address - BASE_ADDR, modulo 2^32; no range check.
  - word = off[18:2]; off[1:0] ignored.
  - SRAM_ADDR = {word, half}, half=0 for the low 16 bits, 1 for the high 16 bits.
- Request: req = wr_en | rd_en. If both are asserted, write wins.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if req, go to LOW with cnt=0; otherwise stay.
  - LOW: cnt increments each cycle; when cnt==WAIT_CYCLES, go to HIGH with cnt=0.
  - HIGH: same counting; when cnt==WAIT_CYCLES, go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- ready = ~req | (state==DONE), combinational.
  - The request is observed in IDLE at cycle 0.
  - ready first reads 1 at cycle 1+2*(WAIT_CYCLES+1): cycle 5 at default parameters.
  - The pipeline advances on that edge. The request seen in the IDLE cycle after DONE is treated as a new request.
- Write phases (LOW/HIGH):
  - SRAM_DQ driven with write_data[15:0] (LOW) or write_data[31:16] (HIGH) for every cycle of the phase.
  - SRAM_WE_N=0 when cnt<WAIT_CYCLES, =1 on the phase's last cycle. This gives address/data hold before the address changes.
  - SRAM_OE_N=1.
- Read phases:
  - SRAM_DQ=Z, SRAM_OE_N=0, SRAM_WE_N=1.
  - Low half captured into an internal register on the last LOW cycle.
  - read_data <= {SRAM_DQ, low_half} on the last HIGH cycle, so it is valid in DONE.
  - read_data holds its value until the next read completes; writes never modify it.
- Outside LOW/HIGH: SRAM_WE_N=1, SRAM_OE_N=1, DQ=Z.
- Request dropped mid-access (protocol violation): the FSM completes the sequence anyway. Its write strobes still fire with the current inputs.

Decomposition:
- sram_pkg holds:
  - state enum: IDLE/LOW/HIGH/DONE;
  - SRAM_ADDR_W=18, SRAM_DATA_W=16;
  - default BASE_ADDR.
- Single module. The phase counter and tristate driver stay inline; no sub-module is warranted.

Test Plan:
- Idle: wr_en=rd_en=0 for 10 cycles -> ready=1 throughout, WE_N=OE_N=1, DQ=Z.
- Write then read: store address=1024+8, data 0xDEADBEEF.
  - SRAM model sees half-addr 4 <= 0xBEEF and half-addr 5 <= 0xDEAD.
  - ready=0 for cycles 0-4, =1 at cycle 5.
  - Subsequent load from 1032 -> read_data=0xDEADBEEF in DONE.
- Back-to-back: two stores (1024 <- 0x11112222, 1028 <- 0x33334444) then two loads -> the correct words are returned. Each access takes 6 cycles including DONE.
- WE_N shaping: during a store, WE_N low exactly one cycle per half; DQ and SRAM_ADDR stable while WE_N=0 and for one cycle after.
- Reset mid-access: assert rst=0 during HIGH of a store -> outputs reset immediately.
  - After release with the request still held, the FSM restarts at IDLE.
  - Completes after 5 more cycles; memory holds the full new word.
- Both enables: wr_en=rd_en=1, address=1040, data 0xA5A5_5A5A -> write is performed; read_data unchanged; a later load returns 0xA5A55A5A.
